// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: source count default, register offsets,
// vector width and FSM state encoding.
package interrupt_controller_pkg;

    localparam int unsigned NsrcDefault = 6;
    localparam int unsigned VecW        = 3;

    localparam logic [2:0] AddrPending   = 3'd0;
    localparam logic [2:0] AddrMask      = 3'd2;
    localparam logic [2:0] AddrInservice = 3'd4;
    localparam logic [2:0] AddrStatus    = 3'd6;

    typedef enum logic {
        StIdle = 1'b0,
        StReq  = 1'b1
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of the input vector (index 0 wins).
module intc_prio_enc
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned N = NsrcDefault
) (
    input  logic [N-1:0]    vec,
    output logic [VecW-1:0] idx,
    output logic            valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = VecW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller with PENDING/MASK/INSERVICE registers and an IDLE/REQ
// handshake FSM. Define INTC_NESTING_EN to allow higher-priority sources to preempt.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned NSRC = NsrcDefault
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            read_enable,
    input  logic            write_enable,
    input  logic [2:0]      address,
    input  logic [15:0]     write_data_in,
    output logic [15:0]     read_data_out,
    output logic            int_req,
    output logic [2:0]      int_vector,
    input  logic            int_ack,
    input  logic            int_eoi
);

    logic [NSRC-1:0] irq_q, pending_q, pending_d, mask_q, mask_d, inservice_q, inservice_d;
    logic [NSRC-1:0] rise, w1c, eligible, ack_set, eoi_clr, vec_oh;
    logic [VecW-1:0] vector_q, vector_d, elig_idx, is_idx;
    logic            armed_q, elig_valid, is_valid, keep;
    intc_state_e     state_q, state_d;
    logic            unused_wdata;

    assign unused_wdata = ^write_data_in[15:NSRC];

    // Edges are suppressed for the first cycle after reset so levels already high are ignored.
    assign rise   = irq_in & ~irq_q & {NSRC{armed_q}};
    assign w1c    = (write_enable && address == AddrPending) ? write_data_in[NSRC-1:0] : '0;
    assign mask_d = (write_enable && address == AddrMask) ? write_data_in[NSRC-1:0] : mask_q;
    assign vec_oh = NSRC'(1) << vector_q;

    intc_prio_enc #(.N(NSRC)) u_is_enc (
        .vec   (inservice_q),
        .idx   (is_idx),
        .valid (is_valid)
    );

`ifdef INTC_NESTING_EN
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = pending_q[i] & mask_q[i] & (!is_valid || (VecW'(i) < is_idx));
        end
    end
`else
    assign eligible = is_valid ? '0 : (pending_q & mask_q);
`endif

    intc_prio_enc #(.N(NSRC)) u_elig_enc (
        .vec   (eligible),
        .idx   (elig_idx),
        .valid (elig_valid)
    );

    // Withdrawal looks at post-edge mask/pending so the request drops right after the write.
    assign keep = |(vec_oh & mask_d & ((pending_q & ~w1c) | rise));

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ack_set  = '0;
        case (state_q)
            StIdle: begin
                if (elig_valid) begin
                    state_d  = StReq;
                    vector_d = elig_idx;
                end
            end
            StReq: begin
                if (int_ack) begin
                    ack_set = vec_oh;
                    state_d = StIdle;
                end else if (!keep) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign eoi_clr     = (int_eoi && is_valid) ? (NSRC'(1) << is_idx) : '0;
    assign pending_d   = (pending_q & ~w1c & ~ack_set) | rise;
    assign inservice_d = (inservice_q & ~eoi_clr) | ack_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_q       <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            mask_q      <= '0;
            inservice_q <= '0;
            state_q     <= StIdle;
            vector_q    <= '0;
        end else begin
            irq_q       <= irq_in;
            armed_q     <= 1'b1;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            inservice_q <= inservice_d;
            state_q     <= state_d;
            vector_q    <= vector_d;
        end
    end

    assign int_req    = (state_q == StReq);
    assign int_vector = vector_q;

    always_comb begin
        read_data_out = '0;
        if (read_enable) begin
            case (address)
                AddrPending:   read_data_out = 16'(pending_q);
                AddrMask:      read_data_out = 16'(mask_q);
                AddrInservice: read_data_out = 16'(inservice_q);
                AddrStatus:    read_data_out = {vector_q[2], 12'b0, int_req, vector_q[1:0]};
                default:       read_data_out = '0;
            endcase
        end
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter NSRC, default 6, number of interrupt sources: 5 debounced buttons plus keyboard, index 0 = highest priority.
REQ-002 SHALL have port clock  input  1  CPU clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-004 SHALL have port irq_in  input  NSRC  raw interrupt source levels.
REQ-005 SHALL have port read_enable  input  1  IO read strobe (ioread AND chip select).
REQ-006 SHALL have port write_enable  input  1  IO write strobe (iowrite AND chip select).
REQ-007 SHALL have port address  input  3  register byte offset.
REQ-008 SHALL have port write_data_in  input  16  IO write data.
REQ-009 SHALL have port read_data_out  output  16  IO read data, zero-extended, 0 when read_enable=0.
REQ-010 SHALL have port int_req  output  1  interrupt request to CPU.
REQ-011 SHALL have port int_vector  output  3  index of the requested source.
REQ-012 SHALL have port int_ack  input  1  one-cycle CPU acceptance pulse.
REQ-013 SHALL have port int_eoi  input  1  one-cycle end-of-interrupt pulse (eret).

Function
REQ-014 SHALL register irq_in each cycle; a 0->1 transition sets the matching PENDING bit on the next edge.
REQ-015 SHALL map registers: 0 PENDING (read; write-1-to-clear), 2 MASK (read/write, 1 = enabled), 4 INSERVICE (read-only), 6 STATUS {13'b0, state, vector[1:0]} with vector[2] in bit 15.
REQ-016 SHALL define eligible = PENDING & MASK & priority above the highest-priority INSERVICE bit.
REQ-017 SHALL run FSM IDLE/REQ: IDLE -> REQ on the edge after eligible != 0, latching int_vector = lowest eligible index.
REQ-018 In REQ SHALL hold int_req=1 and int_vector constant until int_ack or withdrawal.
REQ-019 On int_ack in REQ SHALL clear PENDING[vector], set INSERVICE[vector], return to IDLE; int_req=0 the following cycle.
REQ-020 SHALL withdraw (REQ -> IDLE, int_req=0, no INSERVICE change) if the latched source becomes ineligible by mask write or W1C before int_ack.
REQ-021 SHALL ignore int_ack in IDLE.
REQ-022 On int_eoi SHALL clear the highest-priority set INSERVICE bit; no effect if INSERVICE=0.
REQ-023 Simultaneous new edge and clear (ack or W1C) of the same PENDING bit: set wins.
REQ-024 Simultaneous int_ack and int_eoi: EOI applies to the old INSERVICE, then the ack sets its bit.
REQ-025 Register writes SHALL take effect on the clock edge of the write; reads are combinational.

Reset
REQ-026 Asserting reset SHALL immediately force PENDING=0, MASK=0, INSERVICE=0, edge registers=0, state=IDLE, int_req=0, int_vector=0.
REQ-027 Reset during REQ SHALL drop int_req without acknowledging; an irq_in held high at release SHALL NOT create a pending bit.

Configuration
REQ-028 With INTC_NESTING_EN defined, SHALL allow preemption per REQ-016.
REQ-029 Without INTC_NESTING_EN, eligible SHALL be 0 while INSERVICE != 0 (one interrupt at a time); INSERVICE remains readable.

Structure
REQ-030 A shared package SHALL hold NSRC default, register offsets, and FSM state encoding.
REQ-031 Priority selection SHALL be one sub-module, intc_prio_enc (NSRC-bit vector -> index + valid).

Verification
REQ-032 MASK=6'h3F, pulse irq_in[3] -> PENDING=6'h08 next cycle, int_req=1 with int_vector=3 one cycle later; int_ack -> INSERVICE=6'h08, PENDING=0.
REQ-033 MASK=6'h3F, edges on 5 and 1 in the same cycle -> vector 1 first; after ack, vector 5 is not requested until int_eoi (priority 5 below in-service 1).
REQ-034 With INTC_NESTING_EN: source 4 in service, edge on 0 -> int_req with vector 0; without macro -> no int_req until int_eoi.
REQ-035 In REQ for vector 2, write MASK=6'h3B -> int_req=0 next cycle, INSERVICE unchanged, PENDING[2] still 1.
REQ-036 MASK=0, edge on 2 -> PENDING=6'h04, int_req stays 0; write 16'h0004 to offset 0 -> PENDING=0.
REQ-037 Assert reset while int_req=1 with irq_in=6'h3F held -> all outputs 0 immediately; after release with MASK set, no int_req until a new edge.
